gray_conv_arbiter: RTL and testbench
====================================

// Module: gray_conv_arbiter
// PURPOSE
//  Shares one Gray-to-binary conversion datapath among NREQ requesters.
//  - Round-robin arbiter picks one pending request per cycle.
//  - The winning requester's Gray word is converted (bin[N-1]=gray[N-1], bin[i]=bin[i+1]^gray[i]).
//  - The result, tagged with the requester index, goes into a single registered output stage with valid/ready.
//  - Sits between multiple Gray-coded pointer/encoder sources and a single binary consumer.
// PARAMETERS
//  N     4  Gray/binary word width (>=2)
//  NREQ  4  number of requesters (>=2)
//  IDW   2  requester index width, = clog2(NREQ) (>=1)
// PORTS
//  clk         in   1       single clock, all state updates on rising edge
//  rst         in   1       reset; synchronous, active-high
//  req_valid   in   NREQ    bit i: requester i has a Gray word pending
//  req_gray    in   NREQ*N  requester i word at [i*N +: N]
//  req_ready   out  NREQ    one-hot grant; transfer for i when req_valid[i]&&req_ready[i]
//  resp_valid  out  1       output stage holds a converted word
//  resp_ready  in   1       consumer accepts resp_* this cycle
//  resp_bin    out  N       converted binary word
//  resp_id     out  IDW     index of requester that produced resp_bin
//  conv_count  out  16      completed responses (resp_valid&&resp_ready), saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - resp_valid=0, resp_bin=0, resp_id=0, conv_count=0.
//   - last_grant=NREQ-1, so requester 0 has top priority after reset.
//   - req_ready is all zero while rst=1.
//   - Reset mid-operation discards the held response without completing it.
//  Output-stage FSM:
//   - EMPTY (resp_valid=0) and FULL (resp_valid=1).
//   - can_accept = EMPTY || (FULL && resp_ready).
//   - EMPTY -> FULL on a transfer.
//   - FULL -> EMPTY on resp_ready with no transfer.
//   - FULL -> FULL on resp_ready with a transfer: back-to-back, new data loaded.
//   - FULL with resp_ready=0: resp_bin/resp_id held stable, req_ready all zero.
//  Arbitration (combinational):
//   - Search order is last_grant+1, last_grant+2, ... modulo NREQ.
//   - The first i with req_valid[i]=1 wins.
//   - req_ready[i]=1 only for the winner and only when can_accept && !rst.
//   - req_ready depends combinationally on req_valid and resp_ready.
//   - No request pending: req_ready=0 and last_grant is unchanged.
//  Transfer:
//   - resp_bin <= gray2bin(req_gray[win]), resp_id <= win, last_grant <= win, all on the same edge.
//   - Latency is 1 cycle from transfer edge to resp_valid.
//   - Throughput is 1 word/cycle while resp_ready=1.
//  Fairness: with all requesters valid continuously, grants rotate 0,1,..,NREQ-1,0; a requester waits at most NREQ-1 grants.
//  Width rules:
//   - Conversion is pure XOR prefix, no carries.
//   - Modulo wrap uses compare-to-NREQ-1, not power-of-two masking; NREQ need not be 2^k.
//  conv_count: +1 on each resp_valid&&resp_ready edge; stays at 16'hFFFF once reached.
//  Requesters must hold req_valid/req_gray stable until transferred (not checked).
// TESTING
//  1 Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, conv_count=0; first grant after release is req 0.
//  2 Single req 2, gray=4'b1101, resp_ready=1 -> next cycle resp_valid=1, resp_bin=4'b1001, resp_id=2.
//  3 All 4 valid continuously, resp_ready=1, grays 4'b1000/4'b0110/4'b0000/4'b0001 -> ids 0,1,2,3,0; bins 4'b1111/4'b0100/4'b0000/4'b0001; conv_count +1 per cycle.
//  4 Backpressure: resp_ready=0 after first response -> resp_* stable, req_ready=0; resp_ready=1 for 1 cycle -> next id loaded same edge (back-to-back).
//  5 Reset mid-op: rst=1 while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0, no count increment, priority back to req 0.
//  6 Exhaustive: every requester x all 16 Gray codes with random resp_ready -> resp_bin^(resp_bin>>1)==gray and correct resp_id; no word lost or duplicated.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Several requesters share one Gray-to-binary converter. Each cycle a
//   round-robin arbiter picks one pending requester. That requester's Gray
//   word is converted to binary. The result, tagged with the requester
//   index, is loaded into a single registered output stage that uses a
//   valid/ready handshake.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   req_valid   [NREQ]    requester i has a Gray word pending
//   req_gray    [NREQ*N]  requester i word at [i*N +: N]
//   req_ready   [NREQ]    one-hot grant; a transfer happens when valid&&ready
//   resp_valid            output stage holds a converted word
//   resp_ready            consumer accepts resp_* this cycle
//   resp_bin    [N]       converted binary word
//   resp_id     [IDW]     index of the requester that produced resp_bin
//   conv_count  [16]      completed responses, saturating at 16'hFFFF
module gray_conv_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_gray,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_bin,
  output logic [IDW-1:0]    resp_id,
  output logic [15:0]       conv_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   resp_bin_q, resp_bin_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [15:0]    conv_count_q, conv_count_d;

  logic           can_accept;
  logic           found;
  logic           xfer;
  logic           complete;
  logic [IDW-1:0] win;
  logic [IDW-1:0] arb_idx;
  logic [N-1:0]   win_gray;
  logic [N-1:0]   win_bin;

  // Round-robin search starting just after the last grant. The index wraps
  // by comparing against NREQ-1, so NREQ does not have to be a power of two.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = last_grant_q;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_idx == IDW'(NREQ - 1)) arb_idx = '0;
      else                           arb_idx = arb_idx + 1'b1;
      if (!found && req_valid[arb_idx]) begin
        found = 1'b1;
        win   = arb_idx;
      end
    end
  end

  assign win_gray = req_gray[win*N +: N];

  // Gray-to-binary conversion is an XOR prefix taken from the MSB downward.
  // No carries are involved.
  always_comb begin
    win_bin        = '0;
    win_bin[N-1]   = win_gray[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      win_bin[i] = win_bin[i+1] ^ win_gray[i];
    end
  end

  // The output stage can take a new word when it is empty, or when it is
  // full and its current word is being consumed in the same cycle.
  assign can_accept = (state_q == EMPTY) || resp_ready;
  assign xfer       = found && can_accept && !rst;
  assign complete   = (state_q == FULL) && resp_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign req_ready[gi] = xfer && (win == IDW'(gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    resp_bin_d   = resp_bin_q;
    resp_id_d    = resp_id_q;
    last_grant_d = last_grant_q;
    conv_count_d = conv_count_q;
    if (xfer) begin
      state_d      = FULL;
      resp_bin_d   = win_bin;
      resp_id_d    = win;
      last_grant_d = win;
    end else if (complete) begin
      state_d = EMPTY;
    end
    if (complete && (conv_count_q != 16'hFFFF)) begin
      conv_count_d = conv_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      resp_bin_q   <= '0;
      resp_id_q    <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      conv_count_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_bin_q   <= resp_bin_d;
      resp_id_q    <= resp_id_d;
      last_grant_q <= last_grant_d;
      conv_count_q <= conv_count_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_bin   = resp_bin_q;
  assign resp_id    = resp_id_q;
  assign conv_count = conv_count_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed testbench for gray_conv_arbiter with N=4, NREQ=4, IDW=2.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_gray;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_bin;
  logic [1:0]  resp_id;
  logic [15:0] conv_count;

  int pass_cnt = 0;
  int total    = 0;

  gray_conv_arbiter #(.N(4), .NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_bin   (resp_bin),
    .resp_id    (resp_id),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [3:0] exp_bin3 [4];
    int         exp_id3  [5];
    int         idx [4];
    logic [5:0] sb [$];
    logic [5:0] front;
    int         popped;
    int         cyc;
    logic [3:0] g;

    rst = 1'b1; req_valid = 4'hF; req_gray = 16'h0; resp_ready = 1'b1;
    #1;

    // 1: reset held for two cycles while all requesters are asking.
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_conv_count", conv_count, 16'd0);
    end
    check("rst_resp_bin", resp_bin, 4'd0);
    check("rst_resp_id", resp_id, 2'd0);
    rst = 1'b0;
    #1;
    check("first_grant_req0", req_ready, 4'b0001);
    req_valid = 4'h0;
    #1;
    check("idle_no_grant", req_ready, 4'b0000);

    // 2: a single request from requester 2 with gray 1101 converts to binary 1001.
    req_gray = 16'h0D00;
    req_valid = 4'b0100;
    #1;
    check("single_grant", req_ready, 4'b0100);
    step();
    req_valid = 4'h0;
    #1;
    check("single_valid", resp_valid, 1'b1);
    check("single_bin", resp_bin, 4'b1001);
    check("single_id", resp_id, 2'd2);
    step();
    check("single_drain_valid", resp_valid, 1'b0);
    check("single_count", conv_count, 16'd1);

    // Return priority to requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 3: all four requesters valid continuously, so grants rotate.
    exp_bin3[0] = 4'b1111; exp_bin3[1] = 4'b0100;
    exp_bin3[2] = 4'b0000; exp_bin3[3] = 4'b0001;
    exp_id3[0] = 0; exp_id3[1] = 1; exp_id3[2] = 2; exp_id3[3] = 3; exp_id3[4] = 0;
    req_gray  = {4'b0001, 4'b0000, 4'b0110, 4'b1000};
    req_valid = 4'hF;
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), req_ready, 4'b0001 << exp_id3[k]);
      step();
      check($sformatf("rr_valid%0d", k), resp_valid, 1'b1);
      check($sformatf("rr_id%0d", k), resp_id, exp_id3[k]);
      check($sformatf("rr_bin%0d", k), resp_bin, exp_bin3[exp_id3[k]]);
      check($sformatf("rr_count%0d", k), conv_count, k);
    end

    // 4: backpressure holds the output stage stable and blocks all grants.
    resp_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("bp_req_ready", req_ready, 4'b0000);
      step();
      check("bp_valid", resp_valid, 1'b1);
      check("bp_id", resp_id, 2'd0);
      check("bp_bin", resp_bin, 4'b1111);
      check("bp_count", conv_count, 16'd4);
    end
    resp_ready = 1'b1;
    #1;
    check("b2b_grant", req_ready, 4'b0010);
    step();
    resp_ready = 1'b0;
    #1;
    check("b2b_valid", resp_valid, 1'b1);
    check("b2b_id", resp_id, 2'd1);
    check("b2b_bin", resp_bin, 4'b0100);
    check("b2b_count", conv_count, 16'd5);

    // 5: reset in the middle of operation drops the held word.
    rst = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 4'b0000);
    step();
    check("midrst_valid", resp_valid, 1'b0);
    check("midrst_count", conv_count, 16'd0);
    rst = 1'b0;
    #1;
    check("midrst_priority", req_ready, 4'b0001);

    // 6: each requester sends all 16 codes while resp_ready is random.
    // A scoreboard checks ordering, id and the inverse conversion.
    for (int r = 0; r < 4; r++) idx[r] = 0;
    popped = 0;
    cyc = 0;
    while (cyc < 2000 && !(idx[0] == 16 && idx[1] == 16 && idx[2] == 16 && idx[3] == 16
                           && sb.size() == 0 && !resp_valid)) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 4; r++) begin
        req_valid[r] = (idx[r] < 16);
        req_gray[r*4 +: 4] = 4'(idx[r]);
      end
      #1;
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("ex_unexpected_resp", 1'b1, 1'b0);
        end else begin
          front = sb.pop_front();
          check("ex_id", resp_id, front[5:4]);
          check("ex_gray", resp_bin ^ (resp_bin >> 1), front[3:0]);
          popped++;
        end
      end
      for (int r = 0; r < 4; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          g = 4'(idx[r]);
          sb.push_back({2'(r), g});
          idx[r]++;
        end
      end
      step();
      cyc++;
    end
    check("ex_timeout", (cyc < 2000), 1'b1);
    check("ex_popped", popped, 64);
    check("ex_count", conv_count, 16'd64);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
